// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared state encoding and default LED stripe timing
package led_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, LATCH} state_t;

  localparam int LED_BITS = 24;

  // Defaults for a 25 MHz clock: 400 ns short, 800 ns long, 50 us latch gap
  localparam int S_CYCLES_25M     = 10;
  localparam int L_CYCLES_25M     = 20;
  localparam int RESET_CYCLES_25M = 1250;

endpackage

// File: rtl/led_frame_sequencer_if.sv
// rtl/led_frame_sequencer_if.sv - frame buffer and bit encoder handshake bundle
interface led_frame_sequencer_if
  import led_pkg::*;
#(
  parameter int ADDR_W       = 3,
  parameter int BITS_PER_LED = LED_BITS
);

  logic                    pix_rd;
  logic [ADDR_W-1:0]       pix_addr;
  logic [BITS_PER_LED-1:0] pix_data;
  logic                    pix_valid;
  logic                    new_bit_rqst;
  logic                    bit_to_transmit;
  logic                    all_bits_shifted;
  logic                    s_time_wait;
  logic                    s_time_measured;
  logic                    l_time_wait;
  logic                    l_time_measured;
  logic                    reset_finish;

  modport master (
    output pix_rd, pix_addr, bit_to_transmit, all_bits_shifted,
           s_time_measured, l_time_measured, reset_finish,
    input  pix_data, pix_valid, new_bit_rqst, s_time_wait, l_time_wait
  );

  modport slave (
    input  pix_rd, pix_addr, bit_to_transmit, all_bits_shifted,
           s_time_measured, l_time_measured, reset_finish,
    output pix_data, pix_valid, new_bit_rqst, s_time_wait, l_time_wait
  );

endinterface

// File: rtl/led_frame_sequencer_phase_timer.sv
// rtl/led_frame_sequencer_phase_timer.sv - saturating phase counter with one-shot elapsed pulse
module phase_timer #(
  parameter int CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic phase_wait,
  output logic measured
);

  localparam int CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  // Pulse is scheduled one cycle early so the registered output lines up with cnt == CYCLES-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      measured <= 1'b0;
    end else begin
      measured <= phase_wait && (cnt == CNT_W'(CYCLES - 2));
      if (!phase_wait)
        cnt <= '0;
      else if (cnt != CNT_W'(CYCLES - 1))
        cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_frame_sequencer.sv
// rtl/led_frame_sequencer.sv - fetches GRB pixels and serves them bit by bit to the stripe encoder
module led_frame_sequencer
  import led_pkg::*;
#(
  parameter int NUM_LEDS     = 8,
  parameter int BITS_PER_LED = LED_BITS,
  parameter int ADDR_W       = 3,
  parameter int S_CYCLES     = S_CYCLES_25M,
  parameter int L_CYCLES     = L_CYCLES_25M,
  parameter int RESET_CYCLES = RESET_CYCLES_25M
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun,
  led_frame_sequencer_if.master bus
);

  localparam int BIT_W = $clog2(BITS_PER_LED);
  localparam int LAT_W = $clog2(RESET_CYCLES);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(BITS_PER_LED - 1);
  localparam logic [ADDR_W-1:0] LED_LAST = ADDR_W'(NUM_LEDS - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RESET_CYCLES - 1);

  state_t                  state;
  logic [BITS_PER_LED-1:0] shift_reg;
  logic [BITS_PER_LED-1:0] next_reg;
  logic                    next_valid;
  logic                    rd_pend;
  logic [BIT_W-1:0]        bit_cnt;
  logic [ADDR_W-1:0]       led_cnt;
  logic [LAT_W-1:0]        lat_cnt;
  logic                    pix_rd_q;
  logic [ADDR_W-1:0]       pix_addr_q;
  logic                    all_shifted_q;
  logic                    reset_finish_q;

  assign bus.pix_rd           = pix_rd_q;
  assign bus.pix_addr         = pix_addr_q;
  assign bus.bit_to_transmit  = shift_reg[BITS_PER_LED-1];
  assign bus.all_bits_shifted = all_shifted_q;
  assign bus.reset_finish     = reset_finish_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      underrun       <= 1'b0;
      shift_reg      <= '0;
      next_reg       <= '0;
      next_valid     <= 1'b0;
      rd_pend        <= 1'b0;
      bit_cnt        <= '0;
      led_cnt        <= '0;
      lat_cnt        <= '0;
      pix_rd_q       <= 1'b0;
      pix_addr_q     <= '0;
      all_shifted_q  <= 1'b0;
      reset_finish_q <= 1'b0;
    end else begin
      pix_rd_q       <= 1'b0;
      frame_done     <= 1'b0;
      reset_finish_q <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            pix_rd_q   <= 1'b1;
            pix_addr_q <= '0;
            rd_pend    <= 1'b1;
            busy       <= 1'b1;
            underrun   <= 1'b0;
            next_valid <= 1'b0;
            state      <= FETCH;
          end
        end
        FETCH: begin
          if (bus.pix_valid && rd_pend) begin
            shift_reg <= bus.pix_data;
            bit_cnt   <= '0;
            led_cnt   <= '0;
            rd_pend   <= 1'b0;
            state     <= SHIFT;
            if (NUM_LEDS > 1) begin
              pix_rd_q   <= 1'b1;
              pix_addr_q <= ADDR_W'(1);
              rd_pend    <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (bus.pix_valid && rd_pend) begin
            next_reg   <= bus.pix_data;
            next_valid <= 1'b1;
            rd_pend    <= 1'b0;
          end
          // Later assignments in this branch deliberately override the prefetch capture above
          if (bus.new_bit_rqst) begin
            if (bit_cnt != BIT_LAST) begin
              shift_reg <= shift_reg << 1;
              bit_cnt   <= bit_cnt + BIT_W'(1);
            end else if (led_cnt == LED_LAST) begin
              all_shifted_q <= 1'b1;
              lat_cnt       <= '0;
              state         <= LATCH;
            end else if (next_valid) begin
              shift_reg  <= next_reg;
              led_cnt    <= led_cnt + ADDR_W'(1);
              bit_cnt    <= '0;
              next_valid <= 1'b0;
              if (int'(led_cnt) + 2 < NUM_LEDS) begin
                pix_rd_q   <= 1'b1;
                pix_addr_q <= ADDR_W'(int'(led_cnt) + 2);
                rd_pend    <= 1'b1;
              end
            end else begin
              underrun      <= 1'b1;
              rd_pend       <= 1'b0;
              next_valid    <= 1'b0;
              all_shifted_q <= 1'b1;
              lat_cnt       <= '0;
              state         <= LATCH;
            end
          end
        end
        LATCH: begin
          if (lat_cnt == LAT_LAST) begin
            reset_finish_q <= 1'b1;
            frame_done     <= 1'b1;
            all_shifted_q  <= 1'b0;
            busy           <= 1'b0;
            state          <= IDLE;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  phase_timer #(.CYCLES(S_CYCLES)) u_s_timer (
    .clk        (clk),
    .rst        (rst),
    .phase_wait (bus.s_time_wait),
    .measured   (bus.s_time_measured)
  );

  phase_timer #(.CYCLES(L_CYCLES)) u_l_timer (
    .clk        (clk),
    .rst        (rst),
    .phase_wait (bus.l_time_wait),
    .measured   (bus.l_time_measured)
  );

endmodule

// File: tb/tb_led_frame_sequencer.sv
// tb/tb_led_frame_sequencer.sv - scoreboard bench for led_frame_sequencer
module tb_led_frame_sequencer;

  localparam int NL = 2;
  localparam int SC = 3;
  localparam int LC = 9;
  localparam int RC = 40;

  logic clk = 1'b0;
  logic rst;
  logic frame_start;
  logic busy;
  logic frame_done;
  logic underrun;

  led_frame_sequencer_if #(.ADDR_W(1), .BITS_PER_LED(24)) bus ();

  led_frame_sequencer #(
    .NUM_LEDS     (NL),
    .BITS_PER_LED (24),
    .ADDR_W       (1),
    .S_CYCLES     (SC),
    .L_CYCLES     (LC),
    .RESET_CYCLES (RC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .busy        (busy),
    .frame_done  (frame_done),
    .underrun    (underrun),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  logic [23:0] pixels [2] = '{24'hA50000, 24'h00FF01};
  bit   exp_bits [$];
  int   rd_log [$];
  int   rd_base;
  int   n_checks = 0;
  int   n_fail = 0;

  int          fb_cnt = 0;
  logic [23:0] fb_data;
  bit          slow1 = 1'b0;
  int          stray_seq = 0;
  int          stray_done = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Frame buffer: logs every read and answers after a fixed latency
  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.pix_valid = 1'b0;
      if (fb_cnt > 0) begin
        fb_cnt--;
        if (fb_cnt == 0) begin
          bus.pix_valid = 1'b1;
          bus.pix_data  = fb_data;
        end
      end
      if (bus.pix_rd) begin
        rd_log.push_back(int'(bus.pix_addr));
        fb_data = pixels[bus.pix_addr];
        fb_cnt  = (slow1 && bus.pix_addr == 1'b1) ? 120 : 2;
      end
      if (stray_seq != stray_done) begin
        bus.pix_valid = 1'b1;
        bus.pix_data  = 24'hFFFFFF;
        stray_done    = stray_seq;
      end
    end
  end

  task automatic check_all_zero();
    check_eq("z_busy", busy, 0);
    check_eq("z_frame_done", frame_done, 0);
    check_eq("z_underrun", underrun, 0);
    check_eq("z_pix_rd", bus.pix_rd, 0);
    check_eq("z_pix_addr", bus.pix_addr, 0);
    check_eq("z_bit", bus.bit_to_transmit, 0);
    check_eq("z_abs", bus.all_bits_shifted, 0);
    check_eq("z_s_meas", bus.s_time_measured, 0);
    check_eq("z_l_meas", bus.l_time_measured, 0);
    check_eq("z_reset_finish", bus.reset_finish, 0);
  endtask

  task automatic start_frame(input int npx);
    exp_bits.delete();
    for (int p = 0; p < npx; p++)
      for (int b = 23; b >= 0; b--)
        exp_bits.push_back(pixels[p][b]);
    rd_base = rd_log.size();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check_eq("start_busy", busy, 1);
    check_eq("start_underrun_clr", underrun, 0);
  endtask

  task automatic send_bits(input int n);
    for (int k = 0; k < n; k++) begin
      bit e;
      if (exp_bits.size() == 0) begin
        check_eq("scoreboard_empty", 1, 0);
        return;
      end
      e = exp_bits.pop_front();
      check_eq("bit", bus.bit_to_transmit, e);
      if (k == n - 1) check_eq("abs_early", bus.all_bits_shifted, 0);
      bus.new_bit_rqst = 1'b1;
      tick();
      bus.new_bit_rqst = 1'b0;
      if (k != n - 1) repeat (3) tick();
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (n < RC + 20) begin
      tick();
      n++;
      if (frame_done) break;
    end
    check_eq("latch_len", n, RC);
    check_eq("done_reset_finish", bus.reset_finish, 1);
    check_eq("done_busy", busy, 0);
    check_eq("done_abs", bus.all_bits_shifted, 0);
    tick();
    check_eq("done_pulse_end", frame_done, 0);
    check_eq("rf_pulse_end", bus.reset_finish, 0);
  endtask

  task automatic check_reads(input int nexp);
    check_eq("rd_count", rd_log.size() - rd_base, nexp);
    for (int i = 0; i < nexp && rd_base + i < rd_log.size(); i++)
      check_eq("rd_addr", rd_log[rd_base + i], i);
  endtask

  task automatic full_frame();
    start_frame(NL);
    repeat (6) tick();
    send_bits(48);
    check_eq("abs_set", bus.all_bits_shifted, 1);
    check_eq("abs_busy", busy, 1);
    check_eq("abs_underrun", underrun, 0);
    wait_done();
    check_reads(2);
  endtask

  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    bus.new_bit_rqst = 1'b0;
    bus.s_time_wait = 1'b0;
    bus.l_time_wait = 1'b0;
    repeat (3) tick();
    check_all_zero();
    rst = 1'b0;
    tick();

    // Normal frame, with a second frame_start while busy that must be ignored
    start_frame(NL);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (5) tick();
    send_bits(48);
    check_eq("abs_set", bus.all_bits_shifted, 1);
    check_eq("abs_underrun", underrun, 0);
    wait_done();
    check_reads(2);

    // Bit requests in IDLE leave the shifter alone and trigger no reads
    rd_base = rd_log.size();
    bus.new_bit_rqst = 1'b1;
    tick();
    bus.new_bit_rqst = 1'b0;
    repeat (3) tick();
    check_eq("idle_bit", bus.bit_to_transmit, pixels[1][0]);
    check_reads(0);
    check_eq("idle_busy", busy, 0);

    // Short timer: one pulse per high stretch
    bus.s_time_wait = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check_eq("s_meas_a", bus.s_time_measured, (i == SC - 1));
    end
    bus.s_time_wait = 1'b0;
    tick();
    bus.s_time_wait = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_eq("s_meas_b", bus.s_time_measured, (i == SC - 1));
    end
    bus.s_time_wait = 1'b0;
    tick();

    // Long timer cut short, then a full run alongside the short timer
    bus.l_time_wait = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_eq("l_meas_short", bus.l_time_measured, 0);
    end
    bus.l_time_wait = 1'b0;
    tick();
    check_eq("l_meas_drop", bus.l_time_measured, 0);
    bus.l_time_wait = 1'b1;
    bus.s_time_wait = 1'b1;
    for (int i = 1; i <= LC; i++) begin
      tick();
      check_eq("l_meas_full", bus.l_time_measured, (i == LC - 1));
      check_eq("s_meas_both", bus.s_time_measured, (i == SC - 1));
    end
    bus.l_time_wait = 1'b0;
    bus.s_time_wait = 1'b0;
    tick();

    // Underrun: second pixel arrives far too late
    slow1 = 1'b1;
    start_frame(1);
    repeat (6) tick();
    send_bits(24);
    check_eq("ur_abs", bus.all_bits_shifted, 1);
    check_eq("ur_flag", underrun, 1);
    wait_done();
    check_eq("ur_sticky", underrun, 1);
    slow1 = 1'b0;
    repeat (20) tick();
    full_frame();

    // Reset in the middle of shifting
    start_frame(NL);
    repeat (6) tick();
    send_bits(10);
    #1 rst = 1'b1;
    #1 check_all_zero();
    repeat (2) tick();
    rst = 1'b0;
    rd_base = rd_log.size();
    stray_seq++;
    repeat (5) tick();
    check_eq("stray_bit", bus.bit_to_transmit, 0);
    check_eq("stray_busy", busy, 0);
    check_reads(0);
    full_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/led_frame_sequencer.md
Name: led_frame_sequencer

Overview:
Frame-level controller that sequences the LED-stripe bit encoder (the block driving led_stripe_pin). It fetches 24-bit GRB pixels from a frame buffer and serves them MSB-first on the encoder's new_bit_rqst handshake. It times the encoder's short/long pulse phases, flags end of frame and times the latch (reset) gap. A frame runs from one frame_start pulse to one frame_done pulse.

Parameters:
NUM_LEDS, 8, LEDs per frame (>=1)
BITS_PER_LED, 24, bits per pixel, sent MSB first
ADDR_W, 3, pixel address width; ceil(log2(NUM_LEDS)), minimum 1
S_CYCLES, 10, short-phase length in clk cycles (>=2)
L_CYCLES, 20, long-phase length in clk cycles (>L_CYCLES... >S_CYCLES)
RESET_CYCLES, 1250, latch gap in clk cycles (>=2)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
frame_start  in  1  pulse; start a frame; ignored while busy
busy  out  1  high from accepted frame_start until frame_done
frame_done  out  1  one-cycle pulse at end of latch gap
underrun  out  1  sticky; next pixel was not ready in time
pix_rd  out  1  one-cycle read strobe to the frame buffer
pix_addr  out  ADDR_W  pixel index; valid while pix_rd is high
pix_data  in  BITS_PER_LED  pixel word; sampled when pix_valid is high
pix_valid  in  1  pixel return, >=1 cycle after pix_rd
new_bit_rqst  in  1  encoder has latched bit_to_transmit and wants the next bit
bit_to_transmit  out  1  current bit = shift_reg MSB
all_bits_shifted  out  1  level; last bit consumed, latch gap running
s_time_wait  in  1  encoder is in its short phase
s_time_measured  out  1  one-cycle pulse; short phase elapsed
l_time_wait  in  1  encoder is in its long phase
l_time_measured  out  1  one-cycle pulse; long phase elapsed
reset_finish  out  1  one-cycle pulse; latch gap elapsed (same cycle as frame_done)

Behaviour:
- All outputs are registered. On rst: state IDLE; every output 0; counters, shift_reg, next_reg and next_valid cleared. rst asserted mid-frame aborts the frame and discards any outstanding read.
- At most one pixel read is outstanding. pix_valid arriving with no outstanding read is ignored.
- IDLE: on frame_start, assert pix_rd with pix_addr=0 on the next cycle; set busy=1; clear underrun; go to FETCH.
- FETCH: on pix_valid, load shift_reg and set bit_cnt=0, led_cnt=0, go to SHIFT. If NUM_LEDS>1, issue the prefetch for addr 1 on the following cycle.
- SHIFT, on new_bit_rqst:
  - bit_cnt<BITS_PER_LED-1: shift left, bit_cnt+1.
  - Last bit and led_cnt==NUM_LEDS-1: go to LATCH; all_bits_shifted=1 next cycle.
  - Last bit, led_cnt<NUM_LEDS-1 and next_valid: move next_reg into shift_reg; led_cnt+1; bit_cnt=0; clear next_valid. If led_cnt+2<NUM_LEDS, issue the prefetch for that address.
  - Last bit, led_cnt<NUM_LEDS-1 and !next_valid: set underrun=1, go to LATCH. A late pix_valid is discarded.
- Prefetch: a pix_valid in SHIFT writes next_reg and sets next_valid.
- new_bit_rqst is ignored in IDLE, FETCH and LATCH.
- LATCH: counter runs 0..RESET_CYCLES-1. On the terminal count: pulse reset_finish and frame_done, clear all_bits_shifted and busy, return to IDLE. A frame_start in that same cycle is ignored.
- Phase timers are independent of state:
  - s_cnt increments each cycle s_time_wait is high and clears when it is low.
  - s_time_measured pulses once, in the cycle s_cnt==S_CYCLES-1. s_cnt then saturates, so there is no repeat until s_time_wait drops.
  - The l timer is identical, using L_CYCLES.
  - If both waits are high, both timers run.
- Width rules: bit_cnt is ceil(log2(BITS_PER_LED)) bits. led_cnt is ADDR_W bits and never wraps (terminates at NUM_LEDS-1). Timer widths are sized to their parameter.

Decomposition:
- Shared package led_pkg holds: the state enum (IDLE, FETCH, SHIFT, LATCH), the default timing constants (S_CYCLES, L_CYCLES, RESET_CYCLES at 25 MHz) and BITS_PER_LED.
- One sub-module, phase_timer: parameter CYCLES; ports clk, rst, wait, measured. Instantiate it twice (short, long). It holds the saturating counter and one-shot pulse.

Test Plan:
- NUM_LEDS=2; frame_start; pix_valid 2 cycles after each pix_rd with 0xA50000, 0x00FF01; encoder model answers every 4 cycles -> bit stream 101001010000000000000000 000000001111111100000001. pix_addr sequence is 0 then 1. all_bits_shifted rises after bit 48. reset_finish and frame_done pulse RESET_CYCLES cycles later; busy falls in the same cycle.
- s_time_wait held high 15 cycles, S_CYCLES=3 -> exactly one s_time_measured pulse, on the 3rd high cycle. Drop for 1 cycle, raise again -> a new pulse after 3 cycles.
- l_time_wait high for only 5 cycles, L_CYCLES=9 -> no l_time_measured pulse; counter is 0 after the drop.
- Second pixel's pix_valid withheld until after pixel 0 bit 23 is requested -> underrun=1, state LATCH, frame_done after RESET_CYCLES. The next frame_start clears underrun.
- frame_start while busy, and new_bit_rqst while in IDLE -> no effect: no pix_rd, bit_to_transmit unchanged.
- rst pulsed mid-SHIFT -> all outputs 0 immediately. A pix_valid after reset is ignored. A new frame then runs correctly.
